pkt_hs_arb: RTL
===============

PKT_HS_ARB -- requirements
Module: pkt_hs_arb

Interface
REQ-001 SHALL have parameter NCH, default 2, number of packet source channels (legal 1..8).
REQ-002 SHALL have parameter DW, default 8, data width per channel.
REQ-003 SHALL have parameter GW, default 8, width of the inter-packet gap counter.
REQ-004 clk  input  1  clock; all logic is on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  NCH*DW  per-channel FIFO read data; channel i is in bits [i*DW +: DW].
REQ-007 in_last  input  NCH  per-channel last-byte-of-packet flag.
REQ-008 in_empty  input  NCH  per-channel FIFO empty.
REQ-009 in_rd_ena  output  NCH  per-channel FIFO read strobe.
REQ-010 hs_start  output  1  one-cycle packet start pulse to the HS lane core.
REQ-011 hs_data  output  DW  byte to the HS lane core.
REQ-012 hs_last  output  1  last byte of the current packet.
REQ-013 hs_ack  input  1  lane core consumed hs_data this cycle.
REQ-014 cfg_ena  input  NCH  per-channel enable.
REQ-015 cfg_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-016 cfg_gap  input  GW  minimum idle cycles between packets.
REQ-017 err_clr  input  1  clears err_underrun.
REQ-018 busy  output  1  high in SEND or GAP.
REQ-019 cur_ch  output  3  granted channel index.
REQ-020 pkt_done  output  1  one-cycle strobe when a packet completes.
REQ-021 err_underrun  output  1  sticky underrun flag.

Function
REQ-022 Channel i SHALL be eligible when cfg_ena[i]=1 and in_empty[i]=0.
REQ-023 SHALL implement three states: IDLE, SEND and GAP.
REQ-024 IDLE SHALL stay in IDLE while no channel is eligible.
REQ-025 IDLE with any channel eligible SHALL register the winner into cur_ch and go to SEND on the next edge.
REQ-026 In round-robin mode, the search SHALL start at (last_grant+1) mod NCH and wrap around.
REQ-027 In priority mode, the lowest eligible index SHALL win.
REQ-028 cfg_mode and cfg_ena SHALL only be sampled at the IDLE arbitration.
REQ-029 hs_start SHALL be high exactly on the first cycle of SEND, one cycle after the arbitration cycle.
REQ-030 In SEND, hs_data SHALL equal in_data[cur_ch] and hs_last SHALL equal in_last[cur_ch]; both are combinational muxes.
REQ-031 In SEND, in_rd_ena[cur_ch] SHALL equal hs_ack & ~in_empty[cur_ch]; all other in_rd_ena bits SHALL be 0.
REQ-032 In IDLE and GAP, hs_data and hs_last SHALL be 0 and in_rd_ena SHALL be all 0.
REQ-033 SEND SHALL exit on hs_ack & hs_last & ~in_empty[cur_ch].
  - Exit target is GAP, with counter loaded with cfg_gap, if cfg_gap != 0.
  - Otherwise exit target is IDLE.
  - pkt_done SHALL be high on that same cycle.
  - last_grant SHALL update to cur_ch on that same cycle.
REQ-034 GAP SHALL decrement its counter each cycle and go to IDLE on the edge where the counter equals 1.
  - With cfg_gap=N, the next hs_start SHALL occur no earlier than N+2 cycles after the pkt_done cycle.
REQ-035 If cur_ch is disabled via cfg_ena mid-packet, the packet SHALL still complete.
REQ-036 hs_ack while in_empty[cur_ch]=1 in SEND SHALL set err_underrun; no read is issued and the state is unchanged.
REQ-037 err_clr SHALL clear err_underrun; when err_clr and a new underrun coincide, the set SHALL win.
REQ-038 hs_ack outside SEND SHALL be ignored.
REQ-039 With NCH=1, the block SHALL behave as a single-FIFO reader; cur_ch SHALL be 0 permanently.

Reset
REQ-040 On rst, the block SHALL:
  - go to IDLE, with cur_ch=0 and last_grant=NCH-1 (so channel 0 has first round-robin turn);
  - clear the gap counter, err_underrun, pkt_done and busy;
  - drive hs_start=0 and in_rd_ena=0.
REQ-041 rst asserted mid-packet SHALL abandon the packet with no pkt_done; remaining bytes stay in the source FIFO.

Verification
REQ-042 NCH=2, round-robin, both channels hold 3-byte packets, hs_ack always 1 -> packets alternate ch0,ch1,ch0.
  - hs_start occurs 1 cycle after each IDLE arbitration.
  - pkt_done and hs_last occur on byte 3.
REQ-043 NCH=4, priority mode, channels 3 and 1 eligible -> ch1 is served first; ch3 is served only once ch1 is empty.
REQ-044 cfg_gap=5, back-to-back packets on ch0 -> exactly 5 GAP cycles plus 1 IDLE cycle between pkt_done and the next hs_start.
REQ-045 in_empty[cur_ch] asserted mid-packet with hs_ack=1 -> err_underrun=1 and in_rd_ena=0.
  - Refill ch0 -> packet resumes and completes.
  - err_clr -> err_underrun=0.
REQ-046 rst pulse during byte 2 of a 4-byte packet -> all outputs reach their reset values; next packet starts from channel 0 arbitration.
REQ-047 cfg_ena[0] cleared during a ch0 packet -> packet completes; ch0 is not granted again until re-enabled.

Source files
------------

// File: rtl/pkt_hs_arb.sv
// Packet arbiter: grants one of NCH source FIFOs and streams its packet, byte by byte,
// to the HS lane core, with an optional idle gap enforced between packets.
module pkt_hs_arb #(
  parameter int NCH = 2,
  parameter int DW  = 8,
  parameter int GW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_last,
  input  logic [NCH-1:0]    in_empty,
  output logic [NCH-1:0]    in_rd_ena,
  output logic              hs_start,
  output logic [DW-1:0]     hs_data,
  output logic              hs_last,
  input  logic              hs_ack,
  input  logic [NCH-1:0]    cfg_ena,
  input  logic              cfg_mode,
  input  logic [GW-1:0]     cfg_gap,
  input  logic              err_clr,
  output logic              busy,
  output logic [2:0]        cur_ch,
  output logic              pkt_done,
  output logic              err_underrun
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cur_ch_nxt;
  logic [2:0]    last_grant, last_grant_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic          start_q, start_nxt;
  logic          err_set;

  logic [NCH-1:0] elig;
  logic [NCH-1:0] rot;
  int             off;
  logic           found;
  logic [2:0]     winner;

  logic [DW-1:0]  sel_data;
  logic           sel_last;
  logic           sel_empty;

  assign elig = cfg_ena & ~in_empty;

  // Rotating the doubled request vector turns round-robin into a plain lowest-index search.
  always_comb begin
    off    = cfg_mode ? 0 : (int'(last_grant) + 1) % NCH;
    rot    = NCH'({elig, elig} >> off);
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && rot[i]) begin
        found  = 1'b1;
        winner = 3'((i + off) % NCH);
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_empty = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cur_ch == 3'(i)) begin
        sel_data  = in_data[i*DW +: DW];
        sel_last  = in_last[i];
        sel_empty = in_empty[i];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cur_ch_nxt     = cur_ch;
    last_grant_nxt = last_grant;
    gap_cnt_nxt    = gap_cnt;
    start_nxt      = 1'b0;
    err_set        = 1'b0;
    hs_data        = '0;
    hs_last        = 1'b0;
    in_rd_ena      = '0;
    pkt_done       = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          cur_ch_nxt = winner;
          start_nxt  = 1'b1;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        hs_data = sel_data;
        hs_last = sel_last;
        for (int i = 0; i < NCH; i++)
          in_rd_ena[i] = (cur_ch == 3'(i)) && hs_ack && !sel_empty;
        if (hs_ack && sel_empty) begin
          err_set = 1'b1;
        end else if (hs_ack && sel_last) begin
          pkt_done       = 1'b1;
          last_grant_nxt = cur_ch;
          if (cfg_gap != '0) begin
            gap_cnt_nxt = cfg_gap;
            state_nxt   = GAP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt - GW'(1);
        if (gap_cnt == GW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cur_ch       <= '0;
      last_grant   <= 3'(NCH - 1);
      gap_cnt      <= '0;
      start_q      <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      state        <= state_nxt;
      cur_ch       <= cur_ch_nxt;
      last_grant   <= last_grant_nxt;
      gap_cnt      <= gap_cnt_nxt;
      start_q      <= start_nxt;
      err_underrun <= err_set ? 1'b1 : (err_clr ? 1'b0 : err_underrun);
    end
  end

  assign hs_start = start_q;
  assign busy     = (state != IDLE);

endmodule
